// File: rtl/io_sim_pkg.sv
// Shared definitions for the I/O simulation slave: FSM encoding, word offset and address decode.
package io_sim_pkg;

  localparam int unsigned DW_DEF   = 32;
  localparam int unsigned AW_DEF   = 32;
  localparam int unsigned WORD_OFS = 2;
  localparam int unsigned ST_W     = 2;

  localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
  localparam logic [ST_W-1:0] ST_WAIT = 2'd1;
  localparam logic [ST_W-1:0] ST_ACK  = 2'd2;
  localparam logic [ST_W-1:0] ST_REL  = 2'd3;

  // 64-bit arithmetic so BASE + 4*DEPTH cannot wrap inside the address width.
  function automatic logic addr_hit(input logic [63:0] addr, input logic [63:0] base,
                                    input logic [63:0] depth);
    logic [63:0] top;
    top      = base + (depth << WORD_OFS);
    addr_hit = (addr >= base) && (addr < top) && (addr[1:0] == 2'b00);
  endfunction

  function automatic logic [63:0] word_index(input logic [63:0] addr, input logic [63:0] base);
    logic [63:0] ofs;
    ofs        = addr - base;
    word_index = ofs >> WORD_OFS;
  endfunction

endpackage

// File: rtl/io_sim_step.sv
// Single-step pulse generator: two-flop synchroniser, rising-edge detect, wrapping pulse counter.
module io_sim_step #(
  parameter int unsigned SCW = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           step_in,
  output logic           step,
  output logic [SCW-1:0] step_cnt
);

  logic           sync1_q;
  logic           sync2_q;
  logic           prev_q;
  logic           step_q;
  logic [SCW-1:0] cnt_q;
  logic           rise_c;

  assign rise_c = sync2_q & ~prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      step_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= step_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      step_q  <= rise_c;
      if (rise_c) cnt_q <= cnt_q + SCW'(1);
    end
  end

  assign step     = step_q;
  assign step_cnt = cnt_q;

endmodule

// File: rtl/io_sim_bank.sv
// DLX bus simulation slave: DEPTH-word bank behind a wait-state FSM with four-phase ACK_N,
// out-of-range/misaligned accesses flagged on ERR_N, plus the single-step pulse generator.
module io_sim_bank
  import io_sim_pkg::*;
#(
  parameter int unsigned     DW    = DW_DEF,
  parameter int unsigned     AW    = AW_DEF,
  parameter int unsigned     DEPTH = 16,
  parameter longint unsigned BASE  = 0,
  parameter int unsigned     WAIT  = 2,
  parameter int unsigned     SCW   = 16
) (
  input  logic           CLK_IN,
  input  logic           RST_N_IN,
  input  logic           STEP_IN,
  input  logic           AS_N,
  input  logic           WR_N,
  input  logic [AW-1:0]  MAO,
  input  logic [DW-1:0]  MDO,
  output logic           STEP,
  output logic [SCW-1:0] STEP_CNT,
  output logic           ACK_N,
  output logic           ERR_N,
  output logic [DW-1:0]  DO
);

  localparam int unsigned IDXW = $clog2(DEPTH);
  localparam int unsigned CW   = 4;

  logic [ST_W-1:0] state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            as_n_prev_q;
  logic            wr_q;
  logic            hit_q;
  logic [IDXW-1:0] idx_q;
  logic [DW-1:0]   wdata_q;
  logic            ack_n_q, ack_n_d;
  logic            err_n_q, err_n_d;
  logic [DW-1:0]   do_q, do_d;
  logic            lat_en;
  logic            bank_we;
  logic            req_hit;
  logic [IDXW-1:0] req_idx;
  logic [DW-1:0]   bank_q [DEPTH];

  assign req_hit = addr_hit(64'(MAO), 64'(BASE), 64'(DEPTH));
  assign req_idx = IDXW'(word_index(64'(MAO), 64'(BASE)));

  // A request is a falling AS_N: after reset or a release, AS_N must be seen high first.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ack_n_d = ack_n_q;
    err_n_d = err_n_q;
    do_d    = do_q;
    lat_en  = 1'b0;
    bank_we = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!AS_N && as_n_prev_q) begin
          lat_en  = 1'b1;
          cnt_d   = CW'(WAIT);
          state_d = (WAIT == 0) ? ST_ACK : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (AS_N) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
          if (cnt_q <= CW'(1)) state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        ack_n_d = 1'b0;
        state_d = ST_REL;
        if (!hit_q) begin
          err_n_d = 1'b0;
          do_d    = '0;
        end else if (wr_q) begin
          bank_we = 1'b1;
        end else begin
          do_d = bank_q[idx_q];
        end
      end
      ST_REL: begin
        if (AS_N) begin
          ack_n_d = 1'b1;
          err_n_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK_IN or negedge RST_N_IN) begin
    if (!RST_N_IN) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      as_n_prev_q <= 1'b0;
      wr_q        <= 1'b0;
      hit_q       <= 1'b0;
      idx_q       <= '0;
      wdata_q     <= '0;
      ack_n_q     <= 1'b1;
      err_n_q     <= 1'b1;
      do_q        <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      as_n_prev_q <= AS_N;
      ack_n_q     <= ack_n_d;
      err_n_q     <= err_n_d;
      do_q        <= do_d;
      if (lat_en) begin
        wr_q    <= ~WR_N;
        hit_q   <= req_hit;
        idx_q   <= req_idx;
        wdata_q <= MDO;
      end
    end
  end

  // Bank contents; commits only from the ACK state with the latched write data.
  always_ff @(posedge CLK_IN or negedge RST_N_IN) begin
    if (!RST_N_IN) begin
      for (int unsigned i = 0; i < DEPTH; i++) bank_q[i] <= '0;
    end else if (bank_we) begin
      bank_q[idx_q] <= wdata_q;
    end
  end

  assign ACK_N = ack_n_q;
  assign ERR_N = err_n_q;
  assign DO    = do_q;

  io_sim_step #(
    .SCW(SCW)
  ) u_step (
    .clk     (CLK_IN),
    .rst_n   (RST_N_IN),
    .step_in (STEP_IN),
    .step    (STEP),
    .step_cnt(STEP_CNT)
  );

endmodule

// File: tb/tb_io_sim_bank.sv
// Directed bench for io_sim_bank: WAIT=2/SCW=16 instance plus a WAIT=0/SCW=2 instance on a shared bus.
module tb_io_sim_bank;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        as_n, wr_n;
  logic [31:0] mao, mdo;
  logic        step_a, step_b;
  logic        step_o_a, step_o_b;
  logic [15:0] cnt_a;
  logic [1:0]  cnt_b;
  logic        ack_n_a, ack_n_b, err_n_a, err_n_b;
  logic [31:0] do_a, do_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  io_sim_bank #(.DW(32), .AW(32), .DEPTH(16), .BASE(0), .WAIT(2), .SCW(16)) u_dut (
    .CLK_IN(clk), .RST_N_IN(rst_n), .STEP_IN(step_a), .AS_N(as_n), .WR_N(wr_n),
    .MAO(mao), .MDO(mdo), .STEP(step_o_a), .STEP_CNT(cnt_a), .ACK_N(ack_n_a),
    .ERR_N(err_n_a), .DO(do_a)
  );

  io_sim_bank #(.DW(32), .AW(32), .DEPTH(16), .BASE(0), .WAIT(0), .SCW(2)) u_w0 (
    .CLK_IN(clk), .RST_N_IN(rst_n), .STEP_IN(step_b), .AS_N(as_n), .WR_N(wr_n),
    .MAO(mao), .MDO(mdo), .STEP(step_o_b), .STEP_CNT(cnt_b), .ACK_N(ack_n_b),
    .ERR_N(err_n_b), .DO(do_b)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic wr, input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    as_n = 1'b0; wr_n = ~wr; mao = a; mdo = d;
  endtask

  // Edges after the first AS_N-low sample until ACK_N is seen low; 40 means timeout.
  task automatic wait_ack(input logic sel, output int e);
    e = 0;
    while (e < 40) begin
      @(posedge clk); #1;
      if ((sel ? ack_n_b : ack_n_a) === 1'b0) break;
      e++;
    end
  endtask

  task automatic end_op(input logic sel, input string tag);
    @(posedge clk); #1;
    as_n = 1'b1;
    @(negedge clk);
    check({tag, "/ack_hold"}, 64'(sel ? ack_n_b : ack_n_a), 64'(0));
    @(posedge clk); #1;
    check({tag, "/ack_rel"}, 64'(sel ? ack_n_b : ack_n_a), 64'(1));
    check({tag, "/err_rel"}, 64'(sel ? err_n_b : err_n_a), 64'(1));
    repeat (2) @(posedge clk);
  endtask

  task automatic txn(input string tag, input logic wr, input logic [31:0] a, input logic [31:0] d,
                     input logic exp_err_n, input logic chk_do, input logic [31:0] exp_do);
    int e;
    start_op(wr, a, d);
    wait_ack(1'b0, e);
    check({tag, "/lat"}, 64'(e), 64'(3));
    check({tag, "/err_n"}, 64'(err_n_a), 64'(exp_err_n));
    if (chk_do) check({tag, "/do"}, 64'(do_a), 64'(exp_do));
    end_op(1'b0, tag);
  endtask

  task automatic step_pulse(input logic sel, input int hi_cyc, input int lo_cyc, output int highs);
    highs = 0;
    @(posedge clk); #1;
    if (sel) step_b = 1'b1; else step_a = 1'b1;
    repeat (hi_cyc) begin
      @(negedge clk);
      if ((sel ? step_o_b : step_o_a) === 1'b1) highs++;
    end
    if (sel) step_b = 1'b0; else step_a = 1'b0;
    repeat (lo_cyc) begin
      @(negedge clk);
      if ((sel ? step_o_b : step_o_a) === 1'b1) highs++;
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int e, hits, highs, total;
    logic [4:0] shape;

    rst_n = 1'b0; as_n = 1'b1; wr_n = 1'b1; mao = '0; mdo = '0;
    step_a = 1'b0; step_b = 1'b0;

    // Reset values, during and after reset
    repeat (3) @(posedge clk); #1;
    check("rst/ack_n", 64'(ack_n_a), 64'(1));
    check("rst/err_n", 64'(err_n_a), 64'(1));
    check("rst/do", 64'(do_a), 64'(0));
    check("rst/step_cnt", 64'(cnt_a), 64'(0));
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    check("post_rst/ack_n", 64'(ack_n_a), 64'(1));
    check("post_rst/err_n", 64'(err_n_a), 64'(1));
    check("post_rst/do", 64'(do_a), 64'(0));
    check("post_rst/step", 64'(step_o_a), 64'(0));

    // Reset while in WAIT: dropped write, no ACK until AS_N high then low
    start_op(1'b1, 32'h10, 32'hDEADBEEF);
    @(posedge clk); #1;
    rst_n = 1'b0;
    check("rst_wait/ack_n", 64'(ack_n_a), 64'(1));
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    hits = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (ack_n_a !== 1'b1) hits++;
    end
    check("rst_wait/no_ack", 64'(hits), 64'(0));
    as_n = 1'b1;
    repeat (2) @(posedge clk);
    txn("rst_wait/read10", 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 32'h0);

    // Read after write and an unwritten word
    txn("wr4", 1'b1, 32'h4, 32'h12345678, 1'b1, 1'b0, 32'h0);
    txn("rd4", 1'b0, 32'h4, 32'h0, 1'b1, 1'b1, 32'h12345678);
    txn("rd8", 1'b0, 32'h8, 32'h0, 1'b1, 1'b1, 32'h0);

    // Misses: above range, misaligned, and a write that would alias onto word 1
    txn("miss40", 1'b0, 32'h40, 32'h0, 1'b0, 1'b1, 32'h0);
    txn("rd4b", 1'b0, 32'h4, 32'h0, 1'b1, 1'b1, 32'h12345678);
    txn("miss6", 1'b0, 32'h6, 32'h0, 1'b0, 1'b1, 32'h0);
    txn("miss44w", 1'b1, 32'h44, 32'h00000BAD, 1'b0, 1'b0, 32'h0);
    txn("rd4c", 1'b0, 32'h4, 32'h0, 1'b1, 1'b1, 32'h12345678);

    // Abort: AS_N low for one sampled edge during a write to 0xC
    start_op(1'b1, 32'hC, 32'hCAFEF00D);
    @(posedge clk); #1;
    as_n = 1'b1;
    hits = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (ack_n_a !== 1'b1) hits++;
    end
    check("abort/no_ack", 64'(hits), 64'(0));
    txn("abort/readC", 1'b0, 32'hC, 32'h0, 1'b1, 1'b1, 32'h0);

    // ACK held while AS_N stays low for six more cycles
    start_op(1'b0, 32'h4, 32'h0);
    wait_ack(1'b0, e);
    check("hold/lat", 64'(e), 64'(3));
    hits = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (ack_n_a === 1'b0) hits++;
    end
    check("hold/low_cycles", 64'(hits), 64'(6));
    end_op(1'b0, "hold");

    // WAIT=0 instance: ACK on the edge after AS_N is first sampled low
    start_op(1'b0, 32'h4, 32'h0);
    wait_ack(1'b1, e);
    check("w0/lat", 64'(e), 64'(1));
    check("w0/do", 64'(do_b), 64'(32'h12345678));
    check("w0/err_n", 64'(err_n_b), 64'(1));
    end_op(1'b1, "w0");
    repeat (3) @(posedge clk);

    // Three 100 ns step requests
    for (int i = 0; i < 3; i++) begin
      step_pulse(1'b0, 10, 10, highs);
      check("step/pulse_cycles", 64'(highs), 64'(1));
      check("step/cnt", 64'(cnt_a), 64'(i + 1));
    end

    // Held high for 1 us: one pulse, two cycles after the first sampling edge
    @(posedge clk); #1;
    step_a = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      shape[i] = step_o_a;
    end
    check("held/latency_shape", 64'(shape), 64'(5'b01000));
    highs = 0;
    repeat (95) begin
      @(negedge clk);
      if (step_o_a === 1'b1) highs++;
    end
    step_a = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (step_o_a === 1'b1) highs++;
    end
    check("held/extra_pulses", 64'(highs), 64'(0));
    check("held/cnt", 64'(cnt_a), 64'(4));

    // SCW=2 counter wraps after five pulses
    total = 0;
    for (int i = 0; i < 5; i++) begin
      step_pulse(1'b1, 10, 10, highs);
      total += highs;
    end
    check("wrap/pulse_cycles", 64'(total), 64'(5));
    check("wrap/cnt", 64'(cnt_b), 64'(1));
    check("wrap/other_cnt", 64'(cnt_a), 64'(4));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/io_sim_bank.md
# io_sim_bank

Parametrised successor of the DLX I/O simulation slave. It answers processor bus transactions (AS_N/WR_N/MAO/MDO) from an internal bank of DEPTH words, with a configurable number of wait states and a four-phase ACK_N handshake. Out-of-range addresses are flagged, not silently aliased. A synchronised single-step pulse generator with a step counter is also included. It sits between the DLX bus interface and the board-level step/clock controls in simulation and FPGA builds.

## Interface
- DW, 32: data width; multiple of 8.
- AW, 32: address width.
- DEPTH, 16: number of words in the bank; power of two, ≥2.
- BASE, 0: byte base address; aligned to 4·DEPTH.
- WAIT, 2: wait states inserted before ACK_N asserts; range 0–15.
- SCW, 16: step counter width.

Ports:
- CLK_IN  in  1  system clock; all logic samples on the rising edge.
- RST_N_IN  in  1  reset; asynchronous, active-low.
- STEP_IN  in  1  raw step request (asynchronous, e.g. push-button).
- AS_N  in  1  address strobe, active-low.
- WR_N  in  1  0 = write, 1 = read; valid while AS_N is low.
- MAO  in  AW  byte address; stable while AS_N is low.
- MDO  in  DW  write data; stable while AS_N is low.
- STEP  out  1  one-cycle pulse per STEP_IN rising edge.
- STEP_CNT  out  SCW  count of STEP pulses; wraps.
- ACK_N  out  1  transfer acknowledge, active-low.
- ERR_N  out  1  low together with ACK_N on an out-of-range or misaligned access.
- DO  out  DW  read data; valid while ACK_N is low.

## Operation
- **Reset** (RST_N_IN low, takes effect immediately and overrides any state):
  - ACK_N=1, ERR_N=1, STEP=0, STEP_CNT=0, DO=0.
  - All bank words are 0 and the FSM is in IDLE.
  - An in-flight transaction is dropped. No write is committed, and no ACK follows reset release until AS_N is seen high and then low again.
- **Address decode:**
  - hit = (MAO ≥ BASE) ∧ (MAO < BASE+4·DEPTH) ∧ (MAO[1:0]==0).
  - index = (MAO−BASE)[log2(DEPTH)+1:2].
- **FSM states:** IDLE, WAIT, ACK, REL.
  - IDLE: on AS_N=0, latch WR_N, MAO and MDO, load the wait counter with WAIT, and go to WAIT. If WAIT=0, go directly to ACK.
  - WAIT: decrement the counter. At 0, go to ACK. If AS_N=1, the transaction is aborted: return to IDLE with no write and no ACK.
  - ACK: drive ACK_N=0 for one cycle.
    - Hit write: bank[index] ← latched MDO.
    - Hit read: DO ← bank[index].
    - Miss: no write, DO ← 0, ERR_N=0.
    - Next state is REL.
  - REL: hold ACK_N (and ERR_N if set) low until AS_N=1, then release both high and return to IDLE.
- **No back-to-back transactions:** a new transaction needs AS_N high for at least one edge. DO holds its last value outside ACK.
- **Read-after-write:** a read returns data committed by any earlier acknowledged write.
- **Step path:**
  - STEP_IN passes through a two-flop synchroniser and a rising-edge detector.
  - Each detected edge gives STEP=1 for exactly one cycle and STEP_CNT+1, modulo 2^SCW.
  - A level held high produces one pulse only.
  - The step path is independent of the bus FSM.

## Timing
- AS_N first sampled low at edge k → ACK_N falls at edge k+1+WAIT.
- Write commit and DO update occur at that same edge.
- ACK_N rises at the first edge after AS_N is sampled high.
- STEP_IN rising at edge k (meeting setup) → STEP high during cycle k+2→k+3, so the latency is 2 cycles.
- AS_N, WR_N, MAO and MDO are sampled synchronously. The bus master guarantees setup relative to CLK_IN.

## Structure
- Shared package (io_sim_pkg):
  - FSM state encoding (2 bits).
  - Word-offset constant (2).
  - Function for the hit/index decode.
  - Defaults for DW and AW.
- Sub-module io_sim_step (synchroniser, edge detector, counter), instantiated once.
- FSM and bank live in io_sim_bank.

## Test plan
- **Reset values:** hold RST_N_IN=0, then release → ACK_N=1, ERR_N=1, DO=0, STEP_CNT=0. Assert RST_N_IN=0 while in WAIT → ACK_N stays 1, and the target word stays 0.
- **Read after write, WAIT=2:**
  - Write MAO=0x4, MDO=0x12345678 → ACK_N low 3 edges after AS_N falls.
  - Then read 0x4 → DO=0x12345678, ERR_N=1.
  - Read 0x8 → DO=0.
- **Miss:** read MAO=0x40 with DEPTH=16, and separately MAO=0x6 → ACK_N=0 and ERR_N=0 both times, DO=0. A following read of 0x4 is unchanged.
- **Abort:** AS_N low for 1 cycle only during a write to 0xC (WAIT=2) → no ACK, and bank[3] stays 0.
- **ACK hold:** keep AS_N low for 6 cycles after ACK → ACK_N stays low until the edge after AS_N rises. WAIT=0 variant: ACK at edge k+1.
- **Step path:**
  - Three STEP_IN pulses, each 100 ns wide → three 1-cycle STEP pulses and STEP_CNT=3.
  - STEP_IN held high for 1 µs → one pulse.
  - SCW=2 with five pulses → STEP_CNT wraps to 1.
